// File: rtl/rate_enc_pkg.sv
// Shared widths and ID helpers for the rate-encoding multiplier scheduler and encoder lanes.
package rate_enc_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int A_W_DEF   = 5;
  localparam int B_W_DEF   = 11;
  localparam int OUT_W_DEF = 15;

  // Requester index width; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int ID_W_DEF = id_width(N_REQ_DEF);

  typedef logic [ID_W_DEF-1:0] id_t;

endpackage

// File: rtl/rate_enc_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 upward, wrapping, for the first request.
module rate_enc_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int off = 1; off <= N; off++) begin
      j = IW'((int'(ptr) + off) % N);
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/rate_encoding_mul_sched.sv
// One shared A_W x B_W multiplier, round-robin over N_REQ requesters, 2-stage pipeline with backpressure.
// Define RATE_ENC_MUL_SAT_EN to saturate overflowing products instead of truncating them.
module rate_encoding_mul_sched
  import rate_enc_pkg::*;
#(
  parameter int  N_REQ = N_REQ_DEF,
  parameter int  A_W   = A_W_DEF,
  parameter int  B_W   = B_W_DEF,
  parameter int  OUT_W = OUT_W_DEF,
  localparam int ID_W  = id_width(N_REQ)
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*A_W-1:0] req_a,
  input  logic [N_REQ*B_W-1:0] req_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [OUT_W-1:0]     res_data,
  output logic [ID_W-1:0]      res_id,
  output logic                 res_ovf
);

  localparam int P_W = A_W + B_W;

  logic [ID_W-1:0]  rr_ptr;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_any;

  logic             s1_valid;
  logic [A_W-1:0]   s1_a;
  logic [B_W-1:0]   s1_b;
  logic [ID_W-1:0]  s1_id;

  logic             s1_adv, s2_adv, xfer;
  logic [A_W-1:0]   sel_a;
  logic [B_W-1:0]   sel_b;
  logic [P_W-1:0]   full;
  logic             ovf;
  logic [OUT_W-1:0] prod;

  rate_enc_rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // res_valid is the stage-2 valid bit.
  assign s2_adv    = !res_valid || res_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign xfer      = gnt_any && s1_adv;
  assign req_ready = grant & {N_REQ{s1_adv && ap_rst_n}};

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*A_W +: A_W];
        sel_b = req_b[i*B_W +: B_W];
      end
    end
  end

  assign full = P_W'(s1_a) * P_W'(s1_b);
  assign ovf  = (full >> OUT_W) != '0;

`ifdef RATE_ENC_MUL_SAT_EN
  assign prod = ovf ? {OUT_W{1'b1}} : OUT_W'(full);
`else
  assign prod = OUT_W'(full);
`endif

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      rr_ptr    <= ID_W'(N_REQ - 1);
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_id     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      res_ovf   <= 1'b0;
    end else begin
      if (xfer) rr_ptr <= gnt_idx;
      if (s1_adv) begin
        s1_valid <= xfer;
        if (xfer) begin
          s1_a  <= sel_a;
          s1_b  <= sel_b;
          s1_id <= gnt_idx;
        end
      end
      if (s2_adv) begin
        res_valid <= s1_valid;
        if (s1_valid) begin
          res_data <= prod;
          res_id   <= s1_id;
          res_ovf  <= ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_rate_encoding_mul_sched.sv
// Bench for rate_encoding_mul_sched: directed table plus scoreboard-checked streaming scenarios.
module tb_rate_encoding_mul_sched;

  localparam int N     = 4;
  localparam int A_W   = 5;
  localparam int B_W   = 11;
  localparam int OUT_W = 15;
  localparam int ID_W  = 2;
  localparam int MAXV  = (1 << OUT_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*A_W-1:0]   req_a;
  logic [N*B_W-1:0]   req_b;
  logic               res_valid;
  logic               res_ready;
  logic [OUT_W-1:0]   res_data;
  logic [ID_W-1:0]    res_id;
  logic               res_ovf;

  rate_encoding_mul_sched dut (
    .ap_clk    (clk),
    .ap_rst_n  (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ovf   (res_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int id;
    int ovf;
  } exp_t;

  typedef struct {
    int a;
    int b;
    int lane;
    int data;
    int ovf;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  int   acc_log[$];
  vec_t tbl[6];

  logic             stall_prev = 1'b0;
  logic [OUT_W-1:0] prev_data;
  logic [ID_W-1:0]  prev_id;

  function automatic exp_t model(input int a, input int b, input int id);
    exp_t e;
    int   p;
    p     = a * b;
    e.id  = id;
    e.ovf = (p > MAXV) ? 1 : 0;
`ifdef RATE_ENC_MUL_SAT_EN
    e.data = (p > MAXV) ? MAXV : p;
`else
    e.data = p % (MAXV + 1);
`endif
    return e;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input int a, input int b);
    req_a[i*A_W +: A_W] = A_W'(a);
    req_b[i*B_W +: B_W] = B_W'(b);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    req_valid = '0;
    res_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || res_valid) && n < 20) begin
      tick();
      n++;
    end
    chk("drain_sb_empty", sb.size(), 0);
  endtask

  // Scoreboard: both handshakes complete at the next rising edge, so observe them mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      stall_prev = 1'b0;
    end else begin
      if (res_valid && res_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got id=%0d data=%0d want no result", res_id, res_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (int'(res_data) != e.data || int'(res_id) != e.id || int'(res_ovf) != e.ovf) begin
            errors++;
            $display("FAIL sb_result got data=%0d id=%0d ovf=%0d want data=%0d id=%0d ovf=%0d",
                     res_data, res_id, res_ovf, e.data, e.id, e.ovf);
          end
        end
      end
      if (stall_prev) begin
        checks++;
        if (!res_valid || res_data != prev_data || res_id != prev_id) begin
          errors++;
          $display("FAIL stall_hold got v=%0d data=%0d id=%0d want v=1 data=%0d id=%0d",
                   res_valid, res_data, res_id, prev_data, prev_id);
        end
      end
      stall_prev = res_valid && !res_ready;
      prev_data  = res_data;
      prev_id    = res_id;
      checks++;
      if ($countones(req_ready) > 1) begin
        errors++;
        $display("FAIL ready_onehot got=%b want at most one bit", req_ready);
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back(model(int'(req_a[i*A_W +: A_W]), int'(req_b[i*B_W +: B_W]), i));
          acc_log.push_back(i);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{a: 31, b: 2047, lane: 0, data: 30689, ovf: 1};
    tbl[1] = '{a: 31, b: 1057, lane: 1, data: 32767, ovf: 0};
    tbl[2] = '{a: 17, b: 1928, lane: 2, data: 8,     ovf: 1};
    tbl[3] = '{a: 0,  b: 2047, lane: 3, data: 0,     ovf: 0};
    tbl[4] = '{a: 16, b: 2047, lane: 0, data: 32752, ovf: 0};
    tbl[5] = '{a: 3,  b: 5,    lane: 2, data: 15,    ovf: 0};
`ifdef RATE_ENC_MUL_SAT_EN
    tbl[0].data = 32767;
    tbl[2].data = 32767;
`endif

    // Reset state, with requests pending to confirm no ready leaks out
    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    tick();
    tick();
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_res_id", int'(res_id), 0);
    chk("rst_res_ovf", int'(res_ovf), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    req_valid = '0;
    rst_n     = 1'b1;
    tick();

    // Single ops from the table: accept, one cycle in stage 1, then visible on res_*
    for (int k = 0; k < 6; k++) begin
      int n0;
      n0 = acc_log.size();
      set_lane(tbl[k].lane, tbl[k].a, tbl[k].b);
      req_valid = '0;
      req_valid[tbl[k].lane] = 1'b1;
      tick();
      chk("tbl_accept", acc_log.size(), n0 + 1);
      req_valid = '0;
      chk("tbl_not_yet", int'(res_valid), 0);
      tick();
      chk("tbl_valid", int'(res_valid), 1);
      chk("tbl_data", int'(res_data), tbl[k].data);
      chk("tbl_id", int'(res_id), tbl[k].lane);
      chk("tbl_ovf", int'(res_ovf), tbl[k].ovf);
    end
    drain();

    // All requesters streaming: strict rotation 0,1,2,3 from reset
    do_reset();
    acc_log.delete();
    for (int i = 0; i < N; i++) set_lane(i, i + 4, 300 * (i + 1) + 7);
    req_valid = '1;
    res_ready = 1'b1;
    repeat (12) tick();
    req_valid = '0;
    chk("rr_count", acc_log.size(), 12);
    for (int k = 0; k < 12; k++) chk("rr_order", acc_log[k], k % N);
    drain();

    // Backpressure: only two ops fit before everything stalls
    acc_log.delete();
    req_valid = '1;
    res_ready = 1'b0;
    repeat (5) tick();
    chk("bp_accepts", acc_log.size(), 2);
    chk("bp_valid", int'(res_valid), 1);
    res_ready = 1'b1;
    repeat (3) tick();
    req_valid = '0;
    drain();

    // Single requester gets every cycle
    acc_log.delete();
    set_lane(2, 3, 5);
    req_valid = 4'b0100;
    repeat (8) tick();
    req_valid = '0;
    chk("solo_count", acc_log.size(), 8);
    for (int k = 0; k < 8; k++) chk("solo_lane", acc_log[k], 2);
    drain();

    // Reset with both stages full drops them; priority restarts at req0
    acc_log.delete();
    for (int i = 0; i < N; i++) set_lane(i, 2 * i + 1, 11 * (i + 1));
    req_valid = '1;
    res_ready = 1'b0;
    repeat (2) tick();
    chk("full_accepts", acc_log.size(), 2);
    chk("full_valid", int'(res_valid), 1);
    rst_n = 1'b0;
    tick();
    chk("midrst_valid", int'(res_valid), 0);
    rst_n     = 1'b1;
    res_ready = 1'b1;
    acc_log.delete();
    tick();
    chk("midrst_count", acc_log.size(), 1);
    chk("midrst_first", acc_log[0], 0);
    req_valid = '0;
    drain();

    // Early valid drop: req3 wins, pointer lands on 3 so req0 beats req3 next
    do_reset();
    acc_log.delete();
    res_ready = 1'b0;
    set_lane(0, 7, 9);
    req_valid = 4'b0001;
    repeat (2) tick();
    set_lane(1, 5, 5);
    set_lane(3, 9, 100);
    req_valid = 4'b1010;
    tick();
    chk("drop_stalled", acc_log.size(), 2);
    req_valid = 4'b1000;
    res_ready = 1'b1;
    tick();
    chk("drop_count", acc_log.size(), 3);
    chk("drop_grant", acc_log[2], 3);
    req_valid = 4'b1001;
    tick();
    chk("ptr_after_3", acc_log[3], 0);
    req_valid = '0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
